// File: rtl/mem_stage_access.sv
// MEM stage: aligned lb/lbu/lh/lhu/lw/sb/sh/sw over a req/ack data port, results registered toward MEM_WB.
// Latency: 1 cycle for non-memory ops, 1 + cycles-to-ack for memory ops (ack-timeout aborts after TIMEOUT).
// Backpressure: mem_stall (combinational) freezes upstream while an aligned access is issued or outstanding.
module mem_stage_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [11:0] instruction_in,
  input  logic [14:0] ctrl_msg_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] B_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        valid_out,
  output logic [11:0] instruction_out,
  output logic [14:0] ctrl_msg_out,
  output logic [31:0] wb_data_out,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Everything about the access that must survive while upstream is frozen
  typedef struct packed {
    logic [11:0] instr;
    logic [14:0] ctrl;
    logic [31:0] alu;
    logic        load;
    logic [1:0]  size;
    logic        uns;
  } acc_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  acc_t        acc_q, acc_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [11:0] instr_out_q, instr_out_d;
  logic [14:0] ctrl_out_q, ctrl_out_d;
  logic [31:0] wb_q, wb_d;
  logic        align_q, align_d;
  logic        bus_q, bus_d;

  logic        access;
  logic        is_load;
  logic        misaligned;
  logic        cnt_last;
  logic        stall_c;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign access     = valid_in & (mem_read | mem_write);
  assign is_load    = mem_read;
  assign misaligned = ((mem_size == 2'b01) & alu_in[0]) | (mem_size[1] & (|alu_in[1:0]));
  assign cnt_last   = (cnt_q == CNT_LAST);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = B_in;
    case (mem_size)
      2'b00: begin
        st_be    = 4'b0001 << alu_in[1:0];
        st_wdata = {4{B_in[7:0]}};
      end
      2'b01: begin
        st_be    = alu_in[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{B_in[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = B_in;
      end
    endcase
  end

  // Load extraction uses the latched address/mode; live inputs may already have moved on
  always_comb begin
    ld_byte = 8'h00;
    case (acc_q.alu[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = acc_q.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (acc_q.size)
      2'b00:   ld_data = {{24{~acc_q.uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~acc_q.uns & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    instr_out_d = instr_out_q;
    ctrl_out_d  = ctrl_out_q;
    wb_d        = wb_q;
    align_d     = align_q;
    bus_d       = bus_q;
    stall_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!access) begin
          valid_d     = valid_in;
          instr_out_d = instruction_in;
          ctrl_out_d  = ctrl_msg_in;
          wb_d        = alu_in;
          align_d     = 1'b0;
          bus_d       = 1'b0;
        end else if (misaligned) begin
          valid_d     = 1'b1;
          instr_out_d = instruction_in;
          ctrl_out_d  = ctrl_msg_in;
          wb_d        = 32'h0;
          align_d     = 1'b1;
          bus_d       = 1'b0;
        end else begin
          stall_c     = 1'b1;
          req_d       = 1'b1;
          we_d        = mem_write & ~mem_read;
          addr_d      = {alu_in[31:2], 2'b00};
          be_d        = is_load ? 4'b1111 : st_be;
          wdata_d     = is_load ? 32'h0 : st_wdata;
          cnt_d       = 8'd0;
          acc_d.instr = instruction_in;
          acc_d.ctrl  = ctrl_msg_in;
          acc_d.alu   = alu_in;
          acc_d.load  = is_load;
          acc_d.size  = mem_size;
          acc_d.uns   = mem_unsigned;
          state_d     = S_WAIT;
          valid_d     = 1'b0;
          align_d     = 1'b0;
          bus_d       = 1'b0;
        end
      end

      S_WAIT: begin
        stall_c = ~dmem_ack & ~cnt_last;
        if (dmem_ack) begin
          valid_d     = 1'b1;
          instr_out_d = acc_q.instr;
          ctrl_out_d  = acc_q.ctrl;
          wb_d        = acc_q.load ? ld_data : acc_q.alu;
          align_d     = 1'b0;
          bus_d       = 1'b0;
          req_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_last) begin
          valid_d     = 1'b1;
          instr_out_d = acc_q.instr;
          ctrl_out_d  = acc_q.ctrl;
          wb_d        = 32'h0;
          align_d     = 1'b0;
          bus_d       = 1'b1;
          req_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          valid_d = 1'b0;
          align_d = 1'b0;
          bus_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      acc_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      valid_q     <= 1'b0;
      instr_out_q <= 12'h0;
      ctrl_out_q  <= 15'h0;
      wb_q        <= 32'h0;
      align_q     <= 1'b0;
      bus_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      instr_out_q <= instr_out_d;
      ctrl_out_q  <= ctrl_out_d;
      wb_q        <= wb_d;
      align_q     <= align_d;
      bus_q       <= bus_d;
    end
  end

  // Stall is forced low while reset is held so upstream is never frozen by a dead access
  assign mem_stall       = stall_c & rst_n;
  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_be         = be_q;
  assign dmem_wdata      = wdata_q;
  assign valid_out       = valid_q;
  assign instruction_out = instr_out_q;
  assign ctrl_msg_out    = ctrl_out_q;
  assign wb_data_out     = wb_q;
  assign align_err       = align_q;
  assign bus_err         = bus_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: loads, stores, misalignment, timeout, reset and ALU pass-through.
// Inputs driven 1 time unit after posedge; DUT outputs sampled at negedge or 1 unit after posedge.
module tb_mem_stage_access;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [11:0] instruction_in;
  logic [14:0] ctrl_msg_in;
  logic [31:0] alu_in;
  logic [31:0] B_in;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        valid_out;
  logic [11:0] instruction_out;
  logic [14:0] ctrl_msg_out;
  logic [31:0] wb_data_out;
  logic        align_err;
  logic        bus_err;

  mem_stage_access #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .instruction_in  (instruction_in),
    .ctrl_msg_in     (ctrl_msg_in),
    .alu_in          (alu_in),
    .B_in            (B_in),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_size        (mem_size),
    .mem_unsigned    (mem_unsigned),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .mem_stall       (mem_stall),
    .valid_out       (valid_out),
    .instruction_out (instruction_out),
    .ctrl_msg_out    (ctrl_msg_out),
    .wb_data_out     (wb_data_out),
    .align_err       (align_err),
    .bus_err         (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int          st;
  int          rc;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] ad;
  logic        we;
  logic [31:0] alu_vals [4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one op and plays the memory side. ack_after = WAIT cycles before the ack cycle (-1: never ack).
  // Scrambles the live inputs once the access is outstanding to prove they are latched.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] b, input int ack_after,
                            input logic [31:0] rdata,
                            output int stalls, output int req_cyc, output logic [3:0] be_o,
                            output logic [31:0] wd_o, output logic [31:0] addr_o, output logic we_o);
    int w;
    bit done;
    stalls = 0; req_cyc = 0; be_o = '0; wd_o = '0; addr_o = '0; we_o = 1'b0;
    w = 0; done = 1'b0;
    valid_in = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_in = a; B_in = b; instruction_in = 12'hA5C; ctrl_msg_in = 15'h1234; dmem_ack = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      else done = 1'b1;
      if (dmem_req) begin
        req_cyc++;
        be_o = dmem_be; wd_o = dmem_wdata; addr_o = dmem_addr; we_o = dmem_we;
      end
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (!done && dmem_req) begin
        w++;
        alu_in = 32'hFFFF_FFFF; B_in = 32'h0; instruction_in = 12'h000;
        ctrl_msg_in = 15'h0; mem_unsigned = ~uns;
        if (w == ack_after + 1) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
      end
    end
    if (!done) check_val("stall_bound", {31'b0, done}, 32'd1);
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; instruction_in = '0; ctrl_msg_in = '0; alu_in = '0; B_in = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    alu_vals[0] = 32'h1111_0001; alu_vals[1] = 32'hCAFE_F00D;
    alu_vals[2] = 32'h0000_0000; alu_vals[3] = 32'h8000_0000;

    #12;
    check_val("rst_req",   {31'b0, dmem_req},  32'd0);
    check_val("rst_stall", {31'b0, mem_stall}, 32'd0);
    check_val("rst_valid", {31'b0, valid_out}, 32'd0);
    check_val("rst_wb",    wb_data_out,        32'd0);
    check_val("rst_errs",  {30'b0, align_err, bus_err}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: lw with ack on the 4th WAIT cycle
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, st, rc, be, wd, ad, we);
    check_val("t1_stalls", st, 32'd4);
    check_val("t1_reqcyc", rc, 32'd4);
    check_val("t1_addr",   ad, 32'h100);
    check_val("t1_be",     {28'b0, be}, 32'hF);
    check_val("t1_we",     {31'b0, we}, 32'd0);
    check_val("t1_wb",     wb_data_out, 32'hDEAD_BEEF);
    check_val("t1_valid",  {31'b0, valid_out}, 32'd1);
    check_val("t1_instr",  {20'b0, instruction_out}, 32'hA5C);
    check_val("t1_ctrl",   {17'b0, ctrl_msg_out}, 32'h1234);
    check_val("t1_req_off", {31'b0, dmem_req}, 32'd0);

    // T2: sub-word loads with minimum latency
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h8012_3456, st, rc, be, wd, ad, we);
    check_val("t2_lb_stalls", st, 32'd1);
    check_val("t2_lb_addr", ad, 32'h100);
    check_val("t2_lb", wb_data_out, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h8012_3456, st, rc, be, wd, ad, we);
    check_val("t2_lbu", wb_data_out, 32'h0000_0080);
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 32'h8001_1234, st, rc, be, wd, ad, we);
    check_val("t2_lh", wb_data_out, 32'hFFFF_8001);
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1, 32'h1234_F00D, st, rc, be, wd, ad, we);
    check_val("t2_lhu", wb_data_out, 32'h0000_F00D);
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 0, 32'h0000_7F00, st, rc, be, wd, ad, we);
    check_val("t2_lb_pos", wb_data_out, 32'h0000_007F);
    run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h104, 32'h0, 0, 32'h0BAD_F00D, st, rc, be, wd, ad, we);
    check_val("t2_rdwr_we", {31'b0, we}, 32'd0);
    check_val("t2_rdwr_wb", wb_data_out, 32'h0BAD_F00D);

    // T3: store lanes
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h1234_5678, 1, 32'h0, st, rc, be, wd, ad, we);
    check_val("t3_sb_be", {28'b0, be}, 32'h2);
    check_val("t3_sb_wd", wd, 32'h7878_7878);
    check_val("t3_sb_we", {31'b0, we}, 32'd1);
    check_val("t3_sb_addr", ad, 32'h200);
    check_val("t3_sb_wb", wb_data_out, 32'h201);
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_5678, 0, 32'h0, st, rc, be, wd, ad, we);
    check_val("t3_sh_be", {28'b0, be}, 32'hC);
    check_val("t3_sh_wd", wd, 32'h5678_5678);
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h204, 32'h1234_5678, 0, 32'h0, st, rc, be, wd, ad, we);
    check_val("t3_sw_be", {28'b0, be}, 32'hF);
    check_val("t3_sw_wd", wd, 32'h1234_5678);
    check_val("t3_sw_wb", wb_data_out, 32'h204);

    // T4: misaligned accesses are trapped without touching memory
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 32'h0, st, rc, be, wd, ad, we);
    check_val("t4_lw_req", rc, 32'd0);
    check_val("t4_lw_stall", st, 32'd0);
    check_val("t4_lw_align", {31'b0, align_err}, 32'd1);
    check_val("t4_lw_wb", wb_data_out, 32'h0);
    check_val("t4_lw_valid", {31'b0, valid_out}, 32'd1);
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h201, 32'hFFFF_FFFF, 0, 32'h0, st, rc, be, wd, ad, we);
    check_val("t4_sh_req", rc, 32'd0);
    check_val("t4_sh_align", {31'b0, align_err}, 32'd1);

    // T5: timeout, then ack on the last allowed cycle
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, -1, 32'h0, st, rc, be, wd, ad, we);
    check_val("t5_to_reqcyc", rc, 32'd16);
    check_val("t5_to_stalls", st, 32'd16);
    check_val("t5_to_bus", {31'b0, bus_err}, 32'd1);
    check_val("t5_to_wb", wb_data_out, 32'h0);
    check_val("t5_to_valid", {31'b0, valid_out}, 32'd1);
    check_val("t5_to_req_off", {31'b0, dmem_req}, 32'd0);
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 15, 32'h55AA_55AA, st, rc, be, wd, ad, we);
    check_val("t5_ack16_reqcyc", rc, 32'd16);
    check_val("t5_ack16_bus", {31'b0, bus_err}, 32'd0);
    check_val("t5_ack16_wb", wb_data_out, 32'h55AA_55AA);

    // T6: reset while an access is outstanding
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; alu_in = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("t6_pre_req", {31'b0, dmem_req}, 32'd1);
    check_val("t6_pre_stall", {31'b0, mem_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_req", {31'b0, dmem_req}, 32'd0);
    check_val("t6_rst_stall", {31'b0, mem_stall}, 32'd0);
    check_val("t6_rst_valid", {31'b0, valid_out}, 32'd0);
    valid_in = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU ops back-to-back, with a stray ack that must be ignored
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      alu_in = alu_vals[k]; dmem_ack = (k == 1);
      @(negedge clk);
      check_val("t6_alu_stall", {31'b0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      check_val("t6_alu_wb", wb_data_out, alu_vals[k]);
      check_val("t6_alu_valid", {31'b0, valid_out}, 32'd1);
      check_val("t6_alu_req", {31'b0, dmem_req}, 32'd0);
    end
    valid_in = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    check_val("t6_idle_valid", {31'b0, valid_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
